// File: rtl/sseg_banner_pkg.sv
// Shared constants, state encoding and modulo-10 position helpers for the
// seven-segment banner controller.
package sseg_banner_pkg;

    localparam int          N_DIGITS  = 10;
    localparam int          N_WINDOW  = 4;
    localparam logic [3:0]  POS_RESET = 4'd6;
    localparam logic [7:0]  BLANK     = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    function automatic logic [3:0] pos_add(input logic [3:0] base, input logic [3:0] off);
        logic [4:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 5'(N_DIGITS)) begin
            sum = sum - 5'(N_DIGITS);
        end
        return sum[3:0];
    endfunction

    function automatic logic [3:0] pos_step(input logic [3:0] pos, input logic dir);
        logic [3:0] nxt;
        if (dir) begin
            nxt = (pos == 4'(N_DIGITS - 1)) ? 4'd0 : pos + 4'd1;
        end else begin
            nxt = (pos == 4'd0) ? 4'(N_DIGITS - 1) : pos - 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sseg_banner_ctrl_tick.sv
// Free-running tick divider: emits a one-cycle pulse every TICKS enabled clocks.
module sseg_tick_gen #(
    parameter int TICKS = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic enable,
    input  logic clear,
    output logic pulse
);

    localparam int             CW   = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt;
    logic          at_last;

    assign at_last = (cnt == LAST);
    assign pulse   = enable && !clear && at_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= at_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sseg_banner_ctrl.sv
// Rotating 4-digit window over a 10-entry segment buffer, multiplexed onto one
// display. Optional macro SSEG_START_MARK_EN lights the DP on the digit showing entry 0.
module sseg_banner_ctrl
    import sseg_banner_pkg::*;
#(
    parameter int STEP_TICKS = 20000000,
    parameter int SCAN_TICKS = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wr_valid,
    output logic       o_wr_ready,
    input  logic [3:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_pause,
    input  logic       i_dir,
    output logic [3:0] o_an_n,
    output logic [7:0] o_sseg_n,
    output logic [3:0] o_pos,
    output logic [1:0] o_state,
    output logic       o_wrap
);

    state_e                 state_q, state_d;
    logic                   step_pulse, scan_pulse;
    logic                   step_ok, run_load, vld_p0;
    logic [3:0]             pos_q;
    logic [1:0]             sel_q;
    logic [7:0]             msg_q [N_DIGITS];
    logic [3:0]             idx_p0;
    logic [7:0]             seg_p0;
    logic [N_WINDOW-1:0]    an_p0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stop overrides everything; a step coinciding with stop is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_start)  state_d = ST_RUN;
            ST_RUN:   if (i_pause)  state_d = ST_PAUSE;
            ST_PAUSE: if (!i_pause) state_d = ST_RUN;
            default:                state_d = ST_IDLE;
        endcase
        if (i_stop) begin
            state_d = ST_IDLE;
        end
        o_wr_ready = (state_q != ST_RUN);
        run_load   = (state_q == ST_IDLE) && (state_d == ST_RUN);
        step_ok    = step_pulse && !i_stop;
        vld_p0     = (state_q != ST_IDLE) && (state_d != ST_IDLE);
    end

    sseg_tick_gen #(.TICKS(STEP_TICKS)) u_step_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .enable  (state_q == ST_RUN),
        .clear   (state_q == ST_IDLE),
        .pulse   (step_pulse)
    );

    sseg_tick_gen #(.TICKS(SCAN_TICKS)) u_scan_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .enable  (state_q != ST_IDLE),
        .clear   (state_q == ST_IDLE),
        .pulse   (scan_pulse)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pos_q  <= POS_RESET;
            o_wrap <= 1'b0;
        end else begin
            o_wrap <= step_ok && (i_dir ? (pos_q == 4'(N_DIGITS - 1)) : (pos_q == 4'd0));
            if (run_load) begin
                pos_q <= POS_RESET;
            end else if (step_ok) begin
                pos_q <= pos_step(pos_q, i_dir);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sel_q <= 2'd0;
        end else if (state_q == ST_IDLE) begin
            sel_q <= 2'd0;
        end else if (scan_pulse) begin
            sel_q <= sel_q + 2'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                msg_q[i] <= BLANK;
            end
        end else if (i_wr_valid && o_wr_ready && (i_wr_addr < 4'(N_DIGITS))) begin
            msg_q[i_wr_addr] <= i_wr_data;
        end
    end

    // Stage p0: select buffer entry for the current digit slot
    always_comb begin
        idx_p0 = pos_add(pos_q, {2'b00, sel_q});
        seg_p0 = msg_q[idx_p0];
`ifdef SSEG_START_MARK_EN
        if (idx_p0 == 4'd0) begin
            seg_p0[7] = 1'b0;
        end
`endif
        an_p0 = ~(N_WINDOW'(1) << sel_q);
    end

    // Stage p1: registered display drive, blanked whenever idle now or next
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_an_n   <= 4'hF;
            o_sseg_n <= BLANK;
        end else if (vld_p0) begin
            o_an_n   <= an_p0;
            o_sseg_n <= seg_p0;
        end else begin
            o_an_n   <= 4'hF;
            o_sseg_n <= BLANK;
        end
    end

    assign o_pos   = pos_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_sseg_banner_ctrl.sv
// Scenario bench for sseg_banner_ctrl with short step/scan periods.
module tb_sseg_banner_ctrl;

    localparam int STEP = 8;
    localparam int SCAN = 2;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_wr_valid = 1'b0;
    logic [3:0] i_wr_addr = 4'd0;
    logic [7:0] i_wr_data = 8'd0;
    logic       i_start = 1'b0, i_stop = 1'b0, i_pause = 1'b0, i_dir = 1'b0;
    logic       o_wr_ready, o_wrap;
    logic [3:0] o_an_n, o_pos;
    logic [7:0] o_sseg_n;
    logic [1:0] o_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] mbuf [10];

    typedef struct { logic [3:0] pos; logic wrap; int gap; } step_t;
    step_t exp_q[$];

    sseg_banner_ctrl #(.STEP_TICKS(STEP), .SCAN_TICKS(SCAN)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
        .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_start(i_start), .i_stop(i_stop), .i_pause(i_pause), .i_dir(i_dir),
        .o_an_n(o_an_n), .o_sseg_n(o_sseg_n),
        .o_pos(o_pos), .o_state(o_state), .o_wrap(o_wrap)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish (got running, want finished)");
        $fatal(1);
    end

    function automatic logic [7:0] shown(input int idx);
        logic [7:0] v;
        v = mbuf[idx];
`ifdef SSEG_START_MARK_EN
        if (idx == 0) v[7] = 1'b0;
`endif
        return v;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Waits for o_pos to move, capturing what each digit slot showed meanwhile.
    task automatic wait_change(output int cyc, output logic [31:0] cap,
                               output logic [3:0] seen, output int wraps_in);
        logic [3:0] last;
        last = o_pos; cyc = 0; cap = '0; seen = '0; wraps_in = 0;
        while (o_pos == last && cyc < 64) begin
            if (o_wrap) wraps_in++;
            case (o_an_n)
                4'b1110: begin cap[7:0]   = o_sseg_n; seen[0] = 1'b1; end
                4'b1101: begin cap[15:8]  = o_sseg_n; seen[1] = 1'b1; end
                4'b1011: begin cap[23:16] = o_sseg_n; seen[2] = 1'b1; end
                4'b0111: begin cap[31:24] = o_sseg_n; seen[3] = 1'b1; end
                default: ;
            endcase
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) mbuf[i] = 8'hFF;
        #12;
        n_checks++; if (o_an_n !== 4'hF) $display("FAIL reset_an got %h want F", o_an_n); else n_pass++;
        n_checks++; if (o_sseg_n !== 8'hFF) $display("FAIL reset_sseg got %h want FF", o_sseg_n); else n_pass++;
        n_checks++; if (o_pos !== 4'd6) $display("FAIL reset_pos got %0d want 6", o_pos); else n_pass++;
        n_checks++; if (o_state !== 2'b00) $display("FAIL reset_state got %b want 00", o_state); else n_pass++;
        n_checks++; if (o_wrap !== 1'b0) $display("FAIL reset_wrap got %b want 0", o_wrap); else n_pass++;
        n_checks++; if (o_wr_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", o_wr_ready); else n_pass++;
        tick();
        i_rst_n = 1'b1;
        tick();
        n_checks++; if (o_state !== 2'b00) $display("FAIL post_reset_state got %b want 00", o_state); else n_pass++;
    endtask

    task automatic test_load();
        for (int a = 0; a < 10; a++) begin
            i_wr_valid = 1'b1; i_wr_addr = 4'(a); i_wr_data = 8'hC0 + 8'(a);
            tick();
            mbuf[a] = 8'hC0 + 8'(a);
            n_checks++;
            if (o_an_n !== 4'hF || o_sseg_n !== 8'hFF || o_wr_ready !== 1'b1)
                $display("FAIL load_blank addr %0d got an=%h sseg=%h rdy=%b want F/FF/1", a, o_an_n, o_sseg_n, o_wr_ready);
            else n_pass++;
        end
        i_wr_addr = 4'd12; i_wr_data = 8'h00;
        tick();
        i_wr_valid = 1'b0;
        n_checks++; if (o_an_n !== 4'hF || o_sseg_n !== 8'hFF) $display("FAIL load_addr12_blank got an=%h sseg=%h want F/FF", o_an_n, o_sseg_n); else n_pass++;
    endtask

    task automatic test_rotate_right();
        step_t e; int cyc, wr_in, offs; logic [31:0] cap, cap9; logic [3:0] seen, seen9;
        cap9 = '0; seen9 = '0; offs = 0;
        i_dir = 1'b1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n_checks++; if (o_state !== 2'b01) $display("FAIL right_state got %b want 01", o_state); else n_pass++;
        n_checks++; if (o_pos !== 4'd6) $display("FAIL right_pos0 got %0d want 6", o_pos); else n_pass++;
        n_checks++; if (o_wr_ready !== 1'b0) $display("FAIL right_ready got %b want 0", o_wr_ready); else n_pass++;
        exp_q.push_back('{4'd7, 1'b0, STEP});
        exp_q.push_back('{4'd8, 1'b0, STEP});
        exp_q.push_back('{4'd9, 1'b0, STEP});
        exp_q.push_back('{4'd0, 1'b1, STEP});
        exp_q.push_back('{4'd1, 1'b0, STEP});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_change(cyc, cap, seen, wr_in);
            if (e.pos == 4'd0) begin cap9 = cap; seen9 = seen; end
            n_checks++; if (o_pos !== e.pos) $display("FAIL right_pos got %0d want %0d", o_pos, e.pos); else n_pass++;
            n_checks++; if (cyc + offs != e.gap) $display("FAIL right_gap got %0d want %0d", cyc + offs, e.gap); else n_pass++;
            n_checks++; if (o_wrap !== e.wrap) $display("FAIL right_wrap pos %0d got %b want %b", e.pos, o_wrap, e.wrap); else n_pass++;
            n_checks++; if (wr_in != 0) $display("FAIL right_wrap_spurious got %0d want 0", wr_in); else n_pass++;
            tick();
            n_checks++; if (o_wrap !== 1'b0) $display("FAIL right_wrap_width got %b want 0", o_wrap); else n_pass++;
            offs = 1;
        end
        n_checks++; if (seen9 !== 4'hF) $display("FAIL right_scan_slots got %b want 1111", seen9); else n_pass++;
        n_checks++; if (cap9[15:8] !== shown(0)) $display("FAIL right_pos9_an1 got %h want %h", cap9[15:8], shown(0)); else n_pass++;
        n_checks++; if (cap9[7:0] !== shown(9)) $display("FAIL right_pos9_an0 got %h want %h", cap9[7:0], shown(9)); else n_pass++;
        n_checks++; if (cap9[23:16] !== shown(1)) $display("FAIL right_pos9_an2 got %h want %h", cap9[23:16], shown(1)); else n_pass++;
    endtask

    task automatic test_rotate_left();
        step_t e; int cyc, wr_in; logic [31:0] cap; logic [3:0] seen;
        i_dir = 1'b0;
        exp_q.push_back('{4'd0, 1'b0, STEP});
        exp_q.push_back('{4'd9, 1'b1, STEP});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_change(cyc, cap, seen, wr_in);
            n_checks++; if (o_pos !== e.pos) $display("FAIL left_pos got %0d want %0d", o_pos, e.pos); else n_pass++;
            n_checks++; if (cyc + 1 != e.gap) $display("FAIL left_gap got %0d want %0d", cyc + 1, e.gap); else n_pass++;
            n_checks++; if (o_wrap !== e.wrap) $display("FAIL left_wrap pos %0d got %b want %b", e.pos, o_wrap, e.wrap); else n_pass++;
            tick();
            n_checks++; if (o_wrap !== 1'b0) $display("FAIL left_wrap_width got %b want 0", o_wrap); else n_pass++;
        end
    endtask

    task automatic test_priority();
        i_stop = 1'b1;
        tick();
        n_checks++; if (o_state !== 2'b00) $display("FAIL stop_state got %b want 00", o_state); else n_pass++;
        n_checks++; if (o_an_n !== 4'hF || o_sseg_n !== 8'hFF) $display("FAIL stop_blank got an=%h sseg=%h want F/FF", o_an_n, o_sseg_n); else n_pass++;
        n_checks++; if (o_wr_ready !== 1'b1) $display("FAIL stop_ready got %b want 1", o_wr_ready); else n_pass++;
        i_start = 1'b1;
        tick();
        n_checks++; if (o_state !== 2'b00) $display("FAIL start_stop_state got %b want 00", o_state); else n_pass++;
        i_start = 1'b0; i_stop = 1'b0;
        tick();
        n_checks++; if (o_state !== 2'b00 || o_an_n !== 4'hF) $display("FAIL idle_hold got st=%b an=%h want 00/F", o_state, o_an_n); else n_pass++;
    endtask

    task automatic test_pause_write();
        step_t e; int cyc, wr_in, an_changes; logic [31:0] cap; logic [3:0] seen, prev_an;
        logic [7:0] last_an0; logic seen_an0;
        an_changes = 0; seen_an0 = 1'b0; last_an0 = 8'h00;
        i_dir = 1'b1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n_checks++; if (o_pos !== 4'd6) $display("FAIL pause_start_pos got %0d want 6", o_pos); else n_pass++;
        repeat (3) tick();
        i_pause = 1'b1;
        prev_an = o_an_n;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) begin i_wr_valid = 1'b1; i_wr_addr = 4'd6; i_wr_data = 8'h88; end
            if (i == 11) i_wr_valid = 1'b0;
            tick();
            if (i == 10) mbuf[6] = 8'h88;
            n_checks++; if (o_pos !== 4'd6) $display("FAIL pause_pos cyc %0d got %0d want 6", i, o_pos); else n_pass++;
            if (o_an_n !== prev_an) an_changes++;
            prev_an = o_an_n;
            if (i >= 11 && o_an_n == 4'b1110) begin last_an0 = o_sseg_n; seen_an0 = 1'b1; end
        end
        n_checks++; if (o_state !== 2'b10) $display("FAIL pause_state got %b want 10", o_state); else n_pass++;
        n_checks++; if (o_wr_ready !== 1'b1) $display("FAIL pause_ready got %b want 1", o_wr_ready); else n_pass++;
        n_checks++; if (an_changes != 40 / SCAN) $display("FAIL pause_scan got %0d want %0d", an_changes, 40 / SCAN); else n_pass++;
        n_checks++; if (!seen_an0 || last_an0 !== shown(6)) $display("FAIL pause_write_an0 got %h want %h", last_an0, shown(6)); else n_pass++;
        i_pause = 1'b0;
        // Four counts elapsed before the pause; one more edge to leave PAUSE.
        exp_q.push_back('{4'd7, 1'b0, 1 + (STEP - 4)});
        e = exp_q.pop_front();
        wait_change(cyc, cap, seen, wr_in);
        n_checks++; if (cyc != e.gap) $display("FAIL resume_gap got %0d want %0d", cyc, e.gap); else n_pass++;
        n_checks++; if (o_pos !== e.pos) $display("FAIL resume_pos got %0d want %0d", o_pos, e.pos); else n_pass++;
        n_checks++; if (o_wrap !== e.wrap) $display("FAIL resume_wrap got %b want %b", o_wrap, e.wrap); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        repeat (2) tick();
        #3;
        i_rst_n = 1'b0;
        for (int i = 0; i < 10; i++) mbuf[i] = 8'hFF;
        #1;
        n_checks++; if (o_an_n !== 4'hF || o_sseg_n !== 8'hFF) $display("FAIL async_blank got an=%h sseg=%h want F/FF", o_an_n, o_sseg_n); else n_pass++;
        n_checks++; if (o_pos !== 4'd6) $display("FAIL async_pos got %0d want 6", o_pos); else n_pass++;
        n_checks++; if (o_state !== 2'b00) $display("FAIL async_state got %b want 00", o_state); else n_pass++;
        n_checks++; if (o_wrap !== 1'b0) $display("FAIL async_wrap got %b want 0", o_wrap); else n_pass++;
        tick();
        i_rst_n = 1'b1;
        repeat (4) tick();
        n_checks++; if (o_state !== 2'b00 || o_an_n !== 4'hF) $display("FAIL post_abort_idle got st=%b an=%h want 00/F", o_state, o_an_n); else n_pass++;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        n_checks++; if (o_an_n !== 4'b1110 || o_sseg_n !== shown(6)) $display("FAIL cleared_buf got an=%h sseg=%h want E/%h", o_an_n, o_sseg_n, shown(6)); else n_pass++;
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_rotate_right();
        test_rotate_left();
        test_priority();
        test_pause_write();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sseg_banner_ctrl.md
SSEG_BANNER_CTRL -- requirements
Module: sseg_banner_ctrl

Interface
REQ-001 SHALL have parameter STEP_TICKS, default 20000000, giving clocks per banner rotation step.
REQ-002 SHALL have parameter SCAN_TICKS, default 100000, giving clocks per digit refresh slot.
REQ-003 SHALL have ports i_clk in 1 (system clock) and i_rst_n in 1 (reset); one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports i_wr_valid in 1, o_wr_ready out 1, i_wr_addr in 4 and i_wr_data in 8, forming the message-buffer write port; data is an active-low segment pattern.
REQ-005 SHALL have ports i_start in 1, i_stop in 1 and i_pause in 1 (level), providing sequencing controls.
REQ-006 SHALL have port i_dir in 1: 1 = rotate right (position +1), 0 = rotate left.
REQ-007 SHALL have ports o_an_n out 4 (active-low digit enables, one-hot) and o_sseg_n out 8 (active-low segments, bit 7 = DP).
REQ-008 SHALL have ports o_pos out 4 (window position 0..9), o_state out 2 (00 IDLE, 01 RUN, 10 PAUSE) and o_wrap out 1 (one-cycle pulse).

Function
REQ-009 SHALL hold a 10-entry x 8-bit message buffer; a write occurs when i_wr_valid && o_wr_ready; addr 10..15 is accepted and discarded.
REQ-010 SHALL drive o_wr_ready = 1 in IDLE and PAUSE and 0 in RUN.
REQ-011 SHALL implement FSM transitions IDLE -i_start-> RUN; RUN -i_pause-> PAUSE; PAUSE -!i_pause-> RUN; any state -i_stop-> IDLE.
REQ-012 SHALL give i_stop priority over i_start and i_pause in the same cycle; i_start is ignored outside IDLE.
REQ-013 SHALL, on IDLE->RUN, load position 6 and clear the step counter; the first step occurs STEP_TICKS clocks later.
REQ-014 SHALL run the step counter only in RUN, hold it in PAUSE and clear it in IDLE; the step pulse fires when count == STEP_TICKS-1, then the counter clears.
REQ-015 SHALL, on a step pulse, update position modulo 10 per i_dir sampled that cycle: right 9->0, left 0->9.
REQ-016 SHALL pulse o_wrap for one cycle, coincident with the registered position update, on either wrap (9->0 or 0->9).
REQ-017 SHALL run the scan counter in RUN and PAUSE; each SCAN_TICKS period advances digit select k through 0,1,2,3,0...
REQ-018 SHALL, for digit select k, show buffer[(pos+k) mod 10] on o_sseg_n with o_an_n[k] = 0 and all other enables 1.
REQ-019 SHALL register o_an_n and o_sseg_n, with latency one clock from a select or position change.
REQ-020 SHALL, in IDLE, drive o_an_n = 4'hF and o_sseg_n = 8'hFF (blank).
REQ-021 SHALL show a buffer write made in PAUSE at the next scan slot that selects that entry.

Reset
REQ-022 SHALL, asynchronously on i_rst_n = 0, set state IDLE, pos 6, all counters 0, buffer entries 8'hFF, o_an_n 4'hF, o_sseg_n 8'hFF, o_wrap 0 and o_wr_ready 1.
REQ-023 SHALL, on reset asserted mid-RUN, abort immediately with no wrap pulse; after release, remain in IDLE until i_start.

Configuration
REQ-024 SHALL provide macro SSEG_START_MARK_EN: when defined, the digit currently showing buffer[0] has o_sseg_n[7] forced to 0 (DP lit); when undefined, o_sseg_n[7] is passed through from the buffer unchanged.

Structure
REQ-025 SHALL place N_DIGITS = 10, N_WINDOW = 4, POS_RESET = 6, BLANK = 8'hFF and the state enum type in package sseg_banner_pkg.
REQ-026 SHALL use sub-module sseg_tick_gen (parameter TICKS; inputs enable, clear; output one-cycle pulse), instantiated twice, for step and scan.

Verification (bench uses STEP_TICKS = 8, SCAN_TICKS = 2)
REQ-027 SHALL verify load: write addr 0..9 with data 8'hC0 + addr, plus addr 12 = 8'h00, in IDLE -> outputs stay blank; buffer unchanged by addr 12.
REQ-028 SHALL verify rotate right: i_start, i_dir = 1 -> o_pos 6,7,8,9,0 at 8-clock intervals; o_wrap high exactly one cycle at the 9->0 update; with pos = 9, an[1] shows 8'hC0.
REQ-029 SHALL verify rotate left: i_dir = 0 from pos 1 -> pos 0 then 9, with o_wrap pulse at the 0->9 update.
REQ-030 SHALL verify pause/write: i_pause for 40 clocks -> o_pos frozen, o_wr_ready = 1, scan continues; a write of addr 6 = 8'h88 appears on an[0]; release -> step arrives at the remaining count.
REQ-031 SHALL verify priority: i_start and i_stop high together in IDLE -> remain IDLE; i_stop in RUN -> IDLE next cycle and outputs blank.
REQ-032 SHALL verify reset mid-RUN: i_rst_n low asynchronously -> outputs blank before the next clock edge, pos = 6; with SSEG_START_MARK_EN, the DP is low only on the digit showing buffer[0].
